// File: rtl/nes_pkg.sv
// rtl/nes_pkg.sv - shared NES CPU/PPU types and constants
package nes_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ALIGN,
      READ,
      WAIT,
      WRITE
   } oam_dma_state_t;

   localparam logic [15:0] OAM_DMA_REG_ADDR = 16'h4014;
   localparam int          OAM_SIZE         = 256;

endpackage

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - sprite OAM DMA initiator: stalls the CPU and copies one page into PPU OAM
module oam_dma_ctrl
   import nes_pkg::*;
#(
   parameter int READ_LATENCY = 1,
   parameter int XFER_LEN     = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dma_start,
   input  logic [7:0]  dma_page,
   input  logic [7:0]  oam_start_addr,
   input  logic        cpu_odd_cycle,
   output logic        cpu_stall,
   output logic        dma_busy,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_data_in,
   output logic        oam_dma,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_data_out
);

   localparam logic [7:0] LP_LAST_IDX =
      8'(((XFER_LEN < OAM_SIZE) ? XFER_LEN : OAM_SIZE) - 1);
   localparam logic [1:0] LP_WAIT_INIT = 2'(READ_LATENCY - 2);

   oam_dma_state_t r_state;
   oam_dma_state_t w_next_state;

   logic [7:0]  r_page;
   logic [7:0]  r_base;
   logic        r_odd;
   logic [7:0]  r_idx;
   logic [1:0]  r_wait_cnt;
   logic [7:0]  w_rd_idx;

   logic        r_cpu_stall;
   logic        r_dma_busy;
   logic        r_mem_rd;
   logic [15:0] r_mem_addr;
   logic        r_oam_dma;
   logic [7:0]  r_oam_addr;

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (dma_start) w_next_state = HALT;
         HALT:    w_next_state = r_odd ? ALIGN : READ;
         ALIGN:   w_next_state = READ;
         READ:    w_next_state = (READ_LATENCY > 1) ? WAIT : WRITE;
         WAIT:    if (r_wait_cnt == 2'd0) w_next_state = WRITE;
         WRITE:   w_next_state = (r_idx == LP_LAST_IDX) ? IDLE : READ;
         default: w_next_state = IDLE;
      endcase
   end

   // Index of the byte about to be read; it advances on the WRITE->READ edge.
   assign w_rd_idx = (r_state == WRITE) ? r_idx + 8'd1 : r_idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_page      <= 8'h00;
         r_base      <= 8'h00;
         r_odd       <= 1'b0;
         r_idx       <= 8'h00;
         r_wait_cnt  <= 2'd0;
         r_cpu_stall <= 1'b0;
         r_dma_busy  <= 1'b0;
         r_mem_rd    <= 1'b0;
         r_mem_addr  <= 16'h0000;
         r_oam_dma   <= 1'b0;
         r_oam_addr  <= 8'h00;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            IDLE: begin
               if (dma_start) begin
                  r_page <= dma_page;
                  r_base <= oam_start_addr;
                  r_odd  <= cpu_odd_cycle;
                  r_idx  <= 8'h00;
               end
            end
            READ:  r_wait_cnt <= LP_WAIT_INIT;
            WAIT:  if (r_wait_cnt != 2'd0) r_wait_cnt <= r_wait_cnt - 2'd1;
            WRITE: if (r_idx != LP_LAST_IDX) r_idx <= r_idx + 8'd1;
            default: ;
         endcase

         // Outputs are registered from the state being entered.
         r_cpu_stall <= (w_next_state != IDLE);
         r_dma_busy  <= (w_next_state != IDLE);
         r_mem_rd    <= (w_next_state == READ);
         r_oam_dma   <= (w_next_state == WRITE);
         if (w_next_state == READ)
            r_mem_addr <= {r_page, w_rd_idx};
         if (w_next_state == WRITE)
            r_oam_addr <= r_base + r_idx;
      end
   end

   assign cpu_stall    = r_cpu_stall;
   assign dma_busy     = r_dma_busy;
   assign mem_rd       = r_mem_rd;
   assign mem_addr     = r_mem_addr;
   assign oam_dma      = r_oam_dma;
   assign oam_addr     = r_oam_addr;
   assign oam_data_out = (r_state == WRITE) ? mem_data_in : 8'h00;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb/tb_oam_dma_ctrl.sv - scoreboard bench for oam_dma_ctrl at read latency 1 and 3
module tb_oam_dma_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        dma_start;
   logic        b_dma_start;
   logic [7:0]  dma_page;
   logic [7:0]  oam_start_addr;
   logic        cpu_odd_cycle;

   logic        a_cpu_stall, a_dma_busy, a_mem_rd, a_oam_dma;
   logic [15:0] a_mem_addr;
   logic [7:0]  a_mem_data_in, a_oam_addr, a_oam_data_out;
   logic        b_cpu_stall, b_dma_busy, b_mem_rd, b_oam_dma;
   logic [15:0] b_mem_addr;
   logic [7:0]  b_mem_data_in, b_oam_addr, b_oam_data_out;

   logic [7:0]  mem [0:65535];
   logic [7:0]  a_rd_q;
   logic [7:0]  b_p0, b_p1, b_p2;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [15:0] qa[$];
   logic [15:0] qb[$];
   logic [15:0] a_e, b_e;
   int  a_stall, a_pulses, a_first_rd, a_last_rd, a_start_cyc;
   int  b_stall, b_pulses, b_first_rd, b_last_rd, b_start_cyc;
   bit  a_got_rd, a_prev_dma, b_got_rd, b_prev_dma;
   logic [7:0] a_first_addr, a_last_addr;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Read data is valid only in the exact cycle the latency dictates.
   always @(posedge clk) a_rd_q <= a_mem_rd ? mem[a_mem_addr] : 8'hEE;
   always @(posedge clk) begin
      b_p0 <= b_mem_rd ? mem[b_mem_addr] : 8'hEE;
      b_p1 <= b_p0;
      b_p2 <= b_p1;
   end
   assign a_mem_data_in = a_rd_q;
   assign b_mem_data_in = b_p2;

   oam_dma_ctrl #(.READ_LATENCY(1)) u_dut_a (
      .clk(clk), .reset(reset), .dma_start(dma_start), .dma_page(dma_page),
      .oam_start_addr(oam_start_addr), .cpu_odd_cycle(cpu_odd_cycle),
      .cpu_stall(a_cpu_stall), .dma_busy(a_dma_busy), .mem_addr(a_mem_addr),
      .mem_rd(a_mem_rd), .mem_data_in(a_mem_data_in), .oam_dma(a_oam_dma),
      .oam_addr(a_oam_addr), .oam_data_out(a_oam_data_out)
   );

   oam_dma_ctrl #(.READ_LATENCY(3)) u_dut_b (
      .clk(clk), .reset(reset), .dma_start(b_dma_start), .dma_page(dma_page),
      .oam_start_addr(oam_start_addr), .cpu_odd_cycle(cpu_odd_cycle),
      .cpu_stall(b_cpu_stall), .dma_busy(b_dma_busy), .mem_addr(b_mem_addr),
      .mem_rd(b_mem_rd), .mem_data_in(b_mem_data_in), .oam_dma(b_oam_dma),
      .oam_addr(b_oam_addr), .oam_data_out(b_oam_data_out)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (a_cpu_stall) a_stall++;
            if (dma_start && !a_dma_busy) a_start_cyc = cyc;
            if (a_mem_rd) begin
               if (!a_got_rd) a_first_rd = cyc;
               a_got_rd = 1;
               a_last_rd = cyc;
            end
            check("a_rd_wr_excl", 32'(a_mem_rd & a_oam_dma), 0);
            if (a_oam_dma) begin
               check("a_dma_gap", 32'(a_prev_dma), 0);
               check("a_rd_to_wr", cyc - a_last_rd, 1);
               if (qa.size() == 0) check("a_sb_empty", 1, 0);
               else begin
                  a_e = qa.pop_front();
                  check("a_oam_addr", a_oam_addr, a_e[15:8]);
                  check("a_oam_data", a_oam_data_out, a_e[7:0]);
               end
               if (a_pulses == 0) a_first_addr = a_oam_addr;
               a_last_addr = a_oam_addr;
               a_pulses++;
            end else check("a_data_idle", a_oam_data_out, 0);
            a_prev_dma = a_oam_dma;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (b_cpu_stall) b_stall++;
            if (b_dma_start && !b_dma_busy) b_start_cyc = cyc;
            if (b_mem_rd) begin
               if (!b_got_rd) b_first_rd = cyc;
               b_got_rd = 1;
               b_last_rd = cyc;
            end
            check("b_rd_wr_excl", 32'(b_mem_rd & b_oam_dma), 0);
            if (b_oam_dma) begin
               check("b_dma_gap", 32'(b_prev_dma), 0);
               check("b_rd_to_wr", cyc - b_last_rd, 3);
               if (qb.size() == 0) check("b_sb_empty", 1, 0);
               else begin
                  b_e = qb.pop_front();
                  check("b_oam_addr", b_oam_addr, b_e[15:8]);
                  check("b_oam_data", b_oam_data_out, b_e[7:0]);
               end
               b_pulses++;
            end
            b_prev_dma = b_oam_dma;
         end
      end
   end

   // Called just after a rising edge; the strobe is sampled on the next edge.
   task automatic start_a(input logic [7:0] page, input logic [7:0] base, input bit odd);
      a_stall = 0; a_pulses = 0; a_got_rd = 0;
      for (int i = 0; i < 256; i++)
         qa.push_back({8'(base + 8'(i)), mem[{page, 8'(i)}]});
      dma_page = page; oam_start_addr = base; cpu_odd_cycle = odd; dma_start = 1'b1;
      @(posedge clk); #1;
      dma_start = 1'b0; cpu_odd_cycle = 1'b0;
   endtask

   task automatic finish_a(input string tag, input int exp_stall, input int exp_rd_delay);
      int n;
      n = 0;
      while (!(a_stall > 0 && !a_cpu_stall) && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 3000) check({tag, "_timeout"}, 1, 0);
      check({tag, "_stall"}, a_stall, exp_stall);
      check({tag, "_pulses"}, a_pulses, 256);
      check({tag, "_rd_delay"}, a_first_rd - a_start_cyc, exp_rd_delay);
      check({tag, "_sb_left"}, qa.size(), 0);
   endtask

   initial begin
      for (int a = 0; a < 65536; a++)
         mem[a] = (a[15:8] == 8'h02) ? (a[7:0] ^ 8'h5A) : (a[7:0] ^ a[15:8] ^ 8'hC3);
      reset = 1'b1; dma_start = 1'b0; b_dma_start = 1'b0;
      dma_page = 8'h00; oam_start_addr = 8'h00; cpu_odd_cycle = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_stall", a_cpu_stall, 0);
      check("rst_busy", a_dma_busy, 0);
      check("rst_mem_rd", a_mem_rd, 0);
      check("rst_oam_dma", a_oam_dma, 0);
      check("rst_mem_addr", a_mem_addr, 16'h0000);
      check("rst_oam_addr", a_oam_addr, 8'h00);
      check("rst_oam_data", a_oam_data_out, 8'h00);
      check("rst_b_stall", b_cpu_stall, 0);
      @(posedge clk); #1;

      start_a(8'h02, 8'h00, 1'b0);
      finish_a("t1_even", 513, 2);

      start_a(8'h02, 8'h00, 1'b1);
      finish_a("t2_odd", 514, 3);

      start_a(8'h03, 8'hF0, 1'b0);
      finish_a("t3_wrap", 513, 2);
      check("t3_first_addr", a_first_addr, 8'hF0);
      check("t3_last_addr", a_last_addr, 8'hEF);

      start_a(8'h02, 8'h00, 1'b0);
      repeat (98) @(posedge clk);
      #1 dma_page = 8'h07; dma_start = 1'b1;
      @(posedge clk); #1 dma_start = 1'b0;
      finish_a("t4_restart", 513, 2);

      start_a(8'h05, 8'h10, 1'b0);
      begin
         int n;
         n = 0;
         while (a_pulses < 40 && n < 2000) begin
            @(posedge clk); #1;
            n++;
         end
         if (n >= 2000) check("t5_wait40_timeout", 1, 0);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      qa.delete();
      @(negedge clk);
      check("t5_stall", a_cpu_stall, 0);
      check("t5_oam_dma", a_oam_dma, 0);
      check("t5_busy", a_dma_busy, 0);
      check("t5_mem_rd", a_mem_rd, 0);
      @(posedge clk); #1;
      start_a(8'h02, 8'h00, 1'b0);
      finish_a("t5_rerun", 513, 2);

      start_a(8'hFF, 8'h00, 1'b1);
      finish_a("t7_pageff", 514, 3);

      b_stall = 0; b_pulses = 0; b_got_rd = 0;
      for (int i = 0; i < 256; i++)
         qb.push_back({8'(i), mem[{8'h02, 8'(i)}]});
      dma_page = 8'h02; oam_start_addr = 8'h00; cpu_odd_cycle = 1'b0; b_dma_start = 1'b1;
      @(posedge clk); #1 b_dma_start = 1'b0;
      begin
         int n;
         n = 0;
         while (!(b_stall > 0 && !b_cpu_stall) && n < 3000) begin
            @(posedge clk); #1;
            n++;
         end
         if (n >= 3000) check("t6_timeout", 1, 0);
      end
      check("t6_stall", b_stall, 1025);
      check("t6_pulses", b_pulses, 256);
      check("t6_rd_delay", b_first_rd - b_start_cyc, 2);
      check("t6_sb_left", qb.size(), 0);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
